// File: rtl/hls_saturation_mul_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hls_sat_pkg
// Description : Rounding-mode encodings and the saturating clamp shared by the
//               gain multiplier and the grey-level quantiser.
// Revision    : 1.0 - initial release
// ============================================================================
package hls_sat_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } sat_res_t;

    // Clamp a sign-extended value into an unsigned or two's-complement field of 'width' bits.
    function automatic sat_res_t sat_clamp(input logic signed [63:0] value,
                                           input int unsigned        width,
                                           input logic               is_signed);
        sat_res_t          res;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (is_signed) begin
            hi = (64'sd1 <<< (width - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (width - 1));
        end else begin
            hi = (64'sd1 <<< width) - 64'sd1;
            lo = 64'sd0;
        end
        res.sat = 1'b0;
        res.val = value;
        if (value > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (value < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hls_saturation_mul_core.sv
`default_nettype none
// ============================================================================
// Module      : hls_saturation_mul_core
// Description : Registered multiplier: operand stage plus DEPTH-1 product regs.
// Revision    : 1.0 - initial release
// ============================================================================
module hls_saturation_mul_core
    import hls_sat_pkg::*;
#(
    parameter int A_WIDTH = 20,
    parameter int B_WIDTH = 8,
    parameter int SIGNED  = 0,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       ce,
    input  logic [A_WIDTH-1:0]         a_i,
    input  logic [B_WIDTH-1:0]         b_i,
    output logic [A_WIDTH+B_WIDTH-1:0] p_o
);

    localparam int   PW  = A_WIDTH + B_WIDTH;
    localparam logic SGN = (SIGNED != 0);

    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic [PW-1:0]      a_ext;
    logic [PW-1:0]      b_ext;
    logic [PW-1:0]      prod;

    always_ff @(posedge clk) begin
        if (ce) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    // Extending both operands to full width makes the modular product exact for either signedness.
    assign a_ext = {{B_WIDTH{SGN & a_q[A_WIDTH-1]}}, a_q};
    assign b_ext = {{A_WIDTH{SGN & b_q[B_WIDTH-1]}}, b_q};
    assign prod  = a_ext * b_ext;

    generate
        if (DEPTH == 1) begin : g_comb
            assign p_o = prod;
        end else begin : g_retime
            logic [PW-1:0] p_q [DEPTH-1];
            always_ff @(posedge clk) begin
                if (ce) begin
                    p_q[0] <= prod;
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        p_q[i] <= p_q[i-1];
                    end
                end
            end
            assign p_o = p_q[DEPTH-2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/hls_saturation_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hls_saturation_mul_pipe
// Description : Pipelined gain multiply with shift, round and saturate; valid/ready stall.
// Revision    : 1.0 - initial release
// ============================================================================
module hls_saturation_mul_pipe
    import hls_sat_pkg::*;
#(
    parameter int A_WIDTH    = 20,
    parameter int B_WIDTH    = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 12,
    parameter int NUM_STAGE  = 3,
    parameter int SIGNED     = 0,
    parameter int ROUND_MODE = 1
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 out_sat
);

    localparam int   PW  = A_WIDTH + B_WIDTH;
    localparam int   EW  = PW + 1;
    localparam logic SGN = (SIGNED != 0);
    localparam logic [EW-1:0] RND =
        (ROUND_MODE == ROUND_HALF_UP && SHIFT > 0) ? (EW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;

    logic                 stall;
    logic [NUM_STAGE-1:0] valid_q;
    logic [NUM_STAGE-1:0] valid_d;
    logic [OUT_WIDTH-1:0] dout_q;
    logic [OUT_WIDTH-1:0] dout_d;
    logic                 sat_q;
    logic                 sat_d;
    logic [PW-1:0]        prod;
    logic [EW-1:0]        w_sum;
    logic signed [EW-1:0] w_sum_s;
    logic signed [EW-1:0] w_shr_s;
    logic [EW-1:0]        w_r;
    logic [63:0]          w_r64;
    sat_res_t             w_clamp;
    logic                 w_unused_bits;

    assign stall     = valid_q[NUM_STAGE-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = valid_q[NUM_STAGE-1];
    assign dout      = dout_q;
    assign out_sat   = sat_q;

    hls_saturation_mul_core #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .SIGNED  (SIGNED),
        .DEPTH   (NUM_STAGE - 1)
    ) u_core (
        .clk (ap_clk),
        .ce  (~stall),
        .a_i (din0),
        .b_i (din1),
        .p_o (prod)
    );

    // One guard bit above the product absorbs the rounding constant.
    assign w_sum   = {SGN & prod[PW-1], prod} + RND;
    assign w_sum_s = w_sum;
    assign w_shr_s = w_sum_s >>> SHIFT;

    always_comb begin
        w_r = w_sum >> SHIFT;
        if (SGN) begin
            w_r = w_shr_s;
        end
    end

    assign w_r64         = {{(64 - EW){SGN & w_r[EW-1]}}, w_r};
    assign w_clamp       = sat_clamp(w_r64, OUT_WIDTH, SGN);
    assign dout_d        = w_clamp.val[OUT_WIDTH-1:0];
    assign sat_d         = w_clamp.sat;
    assign w_unused_bits = ^w_clamp.val[63:OUT_WIDTH];

    assign valid_d = {valid_q[NUM_STAGE-2:0], in_valid};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            valid_q <= '0;
            dout_q  <= '0;
            sat_q   <= 1'b0;
        end else if (!stall) begin
            valid_q <= valid_d;
            // Bubbles leave the result register alone so dout only changes with real samples.
            if (valid_q[NUM_STAGE-2]) begin
                dout_q <= dout_d;
                sat_q  <= sat_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hls_saturation_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_hls_saturation_mul_pipe
// Description : Directed vectors and a scoreboarded stream for the saturating multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hls_saturation_mul_pipe;

    logic        clk       = 1'b0;
    logic        ap_rst    = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [19:0] din0      = '0;
    logic [7:0]  din1      = '0;

    logic       ir0, ir1, ir2;
    logic       ov0, ov1, ov2;
    logic [7:0] do0, do1, do2;
    logic       st0, st1, st2;

    int total = 0;
    int bad   = 0;

    logic [19:0] va [16];
    logic [7:0]  vb [16];

    always #5 clk = ~clk;

    hls_saturation_mul_pipe u_dut (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ir0),
        .din0(din0), .din1(din1), .out_valid(ov0), .out_ready(out_ready),
        .dout(do0), .out_sat(st0)
    );

    hls_saturation_mul_pipe #(.ROUND_MODE(0)) u_dut_trunc (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ir1),
        .din0(din0), .din1(din1), .out_valid(ov1), .out_ready(out_ready),
        .dout(do1), .out_sat(st1)
    );

    hls_saturation_mul_pipe #(.SIGNED(1)) u_dut_sgn (
        .ap_clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ir2),
        .din0(din0), .din1(din1), .out_valid(ov2), .out_ready(out_ready),
        .dout(do2), .out_sat(st2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Unsigned, round-half-up, SHIFT=12, 8-bit saturation reference.
    function automatic logic [8:0] ref_u(input logic [19:0] a, input logic [7:0] b);
        logic [29:0] s;
        s = 30'(a) * 30'(b) + 30'd2048;
        s = s >> 12;
        if (s > 30'd255) return {1'b1, 8'hFF};
        return {1'b0, s[7:0]};
    endfunction

    task automatic single(input string tag, input int sel, input logic [19:0] a,
                          input logic [7:0] b, input logic [7:0] ed, input logic es);
        int k;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din0      = a;
        din1      = b;
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (!ov0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_lat"}, k, 3);
        case (sel)
            0: begin check_eq({tag, "_dout"}, do0, ed); check_eq({tag, "_sat"}, st0, es); end
            1: begin check_eq({tag, "_dout"}, do1, ed); check_eq({tag, "_sat"}, st1, es); end
            default: begin check_eq({tag, "_dout"}, do2, ed); check_eq({tag, "_sat"}, st2, es); end
        endcase
    endtask

    task automatic run_stream(input string tag, input int n, input int base,
                              input int st_start, input int st_len, input bit chk_lat);
        logic [8:0] q [$];
        logic [8:0] e;
        logic [7:0] held;
        bit         have_held;
        int         sent, got, cyc, c_acc, c_out;
        sent = 0; got = 0; cyc = 0; c_acc = -1; c_out = -1; have_held = 0; held = '0;
        while ((sent < n || got < n) && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= st_start && cyc < st_start + st_len);
            if (sent < n) begin
                in_valid = 1'b1;
                din0     = va[base+sent];
                din1     = vb[base+sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (ov0 && !out_ready) begin
                if (!have_held) begin
                    held      = do0;
                    have_held = 1;
                end
                check_eq({tag, "_stall_in_ready"}, ir0, 0);
                check_eq({tag, "_stall_hold"}, do0, held);
            end else begin
                have_held = 0;
            end
            if (st_len == 0) check_eq({tag, "_in_ready"}, ir0, 1);
            if (ov0 && c_out < 0) c_out = cyc;
            if (ov0 && out_ready) begin
                if (q.size() == 0) begin
                    check_eq({tag, "_extra_out"}, 1, 0);
                end else begin
                    e = q.pop_front();
                    check_eq({tag, "_dout"}, do0, e[7:0]);
                    check_eq({tag, "_sat"}, st0, e[8]);
                end
                got++;
            end
            if (in_valid && ir0) begin
                if (c_acc < 0) c_acc = cyc;
                q.push_back(ref_u(din0, din1));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq({tag, "_count"}, got, n);
        if (chk_lat) check_eq({tag, "_first_lat"}, c_out - c_acc, 3);
    endtask

    initial begin
        va = '{20'd2048, 20'd2048, 20'hFFFFF, 20'd0, 20'd4096, 20'd12345, 20'd1000, 20'd65536,
               20'd300,  20'd777,  20'd5000,  20'd99999, 20'd1, 20'd40960, 20'd8191, 20'd2047};
        vb = '{8'd128, 8'd3, 8'd255, 8'd255, 8'd200, 8'd17, 8'd255, 8'd20,
               8'd90,  8'd45, 8'd7,  8'd3,   8'd255, 8'd25, 8'd128, 8'd1};

        repeat (2) @(negedge clk);
        ap_rst = 1'b0;
        #1;
        check_eq("rst_out_valid", ov0, 0);
        check_eq("rst_in_ready", ir0, 1);
        check_eq("rst_dout", do0, 0);
        check_eq("rst_sat", st0, 0);

        single("exact",     0, 20'd2048,  8'd128, 8'd64,  1'b0);
        single("round",     0, 20'd2048,  8'd3,   8'd2,   1'b0);
        single("trunc",     1, 20'd2048,  8'd3,   8'd1,   1'b0);
        single("sat_max",   0, 20'hFFFFF, 8'd255, 8'hFF,  1'b1);
        single("zero",      0, 20'd0,     8'd255, 8'd0,   1'b0);
        single("s_neg_sat", 2, 20'h80000, 8'd127, 8'h80,  1'b1);
        single("s_neg_rnd", 2, 20'hFF800, 8'd3,   8'hFF,  1'b0);
        single("s_negneg",  2, 20'hFF800, 8'h80,  8'd64,  1'b0);

        run_stream("stream", 8, 0, 1000, 0, 1'b1);
        run_stream("bp",     8, 8, 4,    5, 1'b0);

        // Three samples in flight behind a stalled output, then a one-cycle reset.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            din0     = va[i];
            din1     = vb[i];
            @(negedge clk);
        end
        in_valid  = 1'b0;
        ap_rst    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        ap_rst = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", ov0, 0);
        check_eq("mid_rst_in_ready", ir0, 1);
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (ov0) stale++;
            end
            check_eq("mid_rst_stale", stale, 0);
        end
        single("post_rst", 0, 20'd2048, 8'd128, 8'd64, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
